bist_run_ctrl: RTL and testbench
================================

// Module: bist_run_ctrl
// PURPOSE
//   Upstream controller for the SRAM BIST engine (bist + u40spsram_256x10 pair).
//   Launches the engine on a start pulse by driving its bist_en input. Optionally
//   repeats the run NUM times and watches b_done/b_err. Enforces a per-run
//   cycle timeout, supports abort, and latches a sticky result set
//   (pass, fail count, run count, last run length) for system/host readback.
// PARAMETERS
//   RUN_W    4      width of num_runs and run_cnt
//   CNT_W    16     width of per-run cycle counter and last_cycles
//   TIMEOUT  4000   max cycles bist_en may stay high in one run before timeout
//   GAP      2      cycles bist_en is held low between consecutive runs (>=1)
// PORTS
//   clock        in   1      system clock, rising edge
//   n_reset      in   1      asynchronous active-low reset
//   start        in   1      1-cycle request to begin a BIST session
//   abort        in   1      1-cycle request to stop the session early
//   num_runs     in   RUN_W  runs per session, sampled at start; 0 treated as 1
//   b_done       in   1      from bist: run finished (level, valid while bist_en=1)
//   b_err        in   1      from bist: run detected mismatch, valid with b_done
//   bist_en      out  1      to bist: enable, high for the whole of each run
//   busy         out  1      session in progress
//   done         out  1      1-cycle pulse at session end
//   pass         out  1      sticky: last session had 0 failures, no timeout/abort
//   fail_cnt     out  RUN_W  runs with b_err=1 or timeout, saturating
//   run_cnt      out  RUN_W  runs completed in current/last session
//   timeout      out  1      sticky: a run exceeded TIMEOUT
//   aborted      out  1      sticky: last session ended by abort
//   last_cycles  out  CNT_W  bist_en-high cycles of last completed run
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; internal counters 0. All outputs are registered.
//   FSM: IDLE -> RUN -> GAP -> (RUN | FINISH) -> IDLE.
//   IDLE: start=1 at edge T -> at T+1: busy=1, bist_en=1, state RUN.
//     The session target is num_runs, or 1 if num_runs=0.
//     Also at T+1: fail_cnt, run_cnt, timeout, aborted and pass clear to 0.
//     last_cycles holds its old value.
//   RUN: the cycle counter starts at 1 on the first bist_en-high cycle and
//     increments once per cycle.
//     b_done=1: run_cnt+1; if b_err=1, fail_cnt+1 (saturates at all-ones).
//       last_cycles <= counter; bist_en=0 next cycle; state GAP.
//     No b_done and counter==TIMEOUT: timeout=1; fail_cnt+1; run_cnt+1; bist_en=0;
//       state FINISH. No further runs.
//     b_done and TIMEOUT reached in the same cycle: b_done wins, no timeout.
//   GAP: bist_en=0 for exactly GAP cycles, so the bist engine resets.
//     Then: run_cnt==target -> FINISH; otherwise RUN with the counter restarted.
//   FINISH (1 cycle): done=1; busy=0 on the next cycle.
//     pass = (fail_cnt==0 && !timeout && !aborted). The FSM then returns to IDLE.
//   abort=1 in RUN or GAP: bist_en=0 next cycle; aborted=1; state FINISH.
//     A run cut short by abort is not counted. abort has priority over b_done in
//     the same cycle. abort in IDLE or FINISH is ignored.
//   start while busy=1 or in FINISH: ignored, no queueing.
//   b_done/b_err are ignored whenever bist_en=0.
//   The result outputs hold until the next accepted start.
//   Reset mid-session: bist_en drops asynchronously and all state clears.
// TESTING
//   num_runs=1, bist returns b_done with b_err=0 after 1540 cycles ->
//     done pulse, pass=1, run_cnt=1, fail_cnt=0, last_cycles=1540.
//   num_runs=3; run 2 returns b_err=1 ->
//     bist_en low exactly GAP=2 cycles between runs; run_cnt=3, fail_cnt=1, pass=0.
//   num_runs=0 -> exactly one run executed, run_cnt=1.
//   b_done never asserted -> bist_en falls after 4000 high cycles;
//     timeout=1, fail_cnt=1, pass=0, done pulses once.
//   abort in the same cycle as b_done on run 1 of 2 ->
//     aborted=1, run_cnt=0, pass=0.
//   Extra start during busy and n_reset low mid-run ->
//     start has no effect; reset forces bist_en=0 and all outputs to 0 immediately.

Source files
------------

// File: rtl/bist_run_ctrl.sv
// Purpose: sequences SRAM BIST sessions (repeat, timeout, abort) and holds a sticky result set.
// Latency: bist_en rises one cycle after an accepted start; done pulses GAP cycles after the last b_done.
// Backpressure: none; start is dropped while a session is active, abort is honoured only in RUN/GAP.
module bist_run_ctrl #(
  parameter int RUN_W   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4000,
  parameter int GAP     = 2
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [RUN_W-1:0] num_runs,
  input  logic             b_done,
  input  logic             b_err,
  output logic             bist_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [RUN_W-1:0] fail_cnt,
  output logic [RUN_W-1:0] run_cnt,
  output logic             timeout,
  output logic             aborted,
  output logic [CNT_W-1:0] last_cycles
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX  = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [RUN_W-1:0] target, target_nxt;
  logic             bist_en_nxt, busy_nxt, done_nxt, pass_nxt;
  logic             timeout_nxt, aborted_nxt;
  logic [RUN_W-1:0] fail_cnt_nxt, run_cnt_nxt;
  logic [CNT_W-1:0] last_cycles_nxt;
  logic [RUN_W-1:0] fail_inc;

  // Saturating increment of the failure counter.
  always_comb begin
    fail_inc = (fail_cnt == RUN_MAX) ? fail_cnt : fail_cnt + RUN_ONE;
  end

  // Next-state and next-output computation for the session FSM.
  always_comb begin
    state_nxt       = state;
    cyc_cnt_nxt     = cyc_cnt;
    gap_cnt_nxt     = gap_cnt;
    target_nxt      = target;
    bist_en_nxt     = bist_en;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    pass_nxt        = pass;
    timeout_nxt     = timeout;
    aborted_nxt     = aborted;
    fail_cnt_nxt    = fail_cnt;
    run_cnt_nxt     = run_cnt;
    last_cycles_nxt = last_cycles;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_RUN;
          bist_en_nxt  = 1'b1;
          busy_nxt     = 1'b1;
          cyc_cnt_nxt  = CNT_W'(1);
          target_nxt   = (num_runs == '0) ? RUN_ONE : num_runs;
          fail_cnt_nxt = '0;
          run_cnt_nxt  = '0;
          timeout_nxt  = 1'b0;
          aborted_nxt  = 1'b0;
          pass_nxt     = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          // An aborted run is discarded: no run/fail accounting.
          state_nxt   = S_FINISH;
          bist_en_nxt = 1'b0;
          aborted_nxt = 1'b1;
        end else if (b_done && bist_en) begin
          // Completion beats a timeout landing in the same cycle.
          run_cnt_nxt     = run_cnt + RUN_ONE;
          fail_cnt_nxt    = b_err ? fail_inc : fail_cnt;
          last_cycles_nxt = cyc_cnt;
          bist_en_nxt     = 1'b0;
          gap_cnt_nxt     = '0;
          state_nxt       = S_GAP;
        end else if (cyc_cnt == TO_LAST) begin
          timeout_nxt  = 1'b1;
          fail_cnt_nxt = fail_inc;
          run_cnt_nxt  = run_cnt + RUN_ONE;
          bist_en_nxt  = 1'b0;
          state_nxt    = S_FINISH;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt   = S_FINISH;
          aborted_nxt = 1'b1;
        end else if (gap_cnt == GAP_LAST) begin
          // bist_en has been low for GAP cycles, engine is back in reset.
          if (run_cnt == target) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt   = S_RUN;
            bist_en_nxt = 1'b1;
            cyc_cnt_nxt = CNT_W'(1);
          end
        end else begin
          gap_cnt_nxt = gap_cnt + CNT_W'(1);
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt   = S_IDLE;
        busy_nxt    = 1'b0;
        bist_en_nxt = 1'b0;
      end
    endcase

    // Result is published together with the done pulse, from the final counts.
    if (state_nxt == S_FINISH) begin
      done_nxt = 1'b1;
      pass_nxt = (fail_cnt_nxt == '0) && !timeout_nxt && !aborted_nxt;
    end
  end

  // State and registered outputs; reset drops bist_en asynchronously.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      cyc_cnt     <= '0;
      gap_cnt     <= '0;
      target      <= '0;
      bist_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      aborted     <= 1'b0;
      fail_cnt    <= '0;
      run_cnt     <= '0;
      last_cycles <= '0;
    end else begin
      state       <= state_nxt;
      cyc_cnt     <= cyc_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      target      <= target_nxt;
      bist_en     <= bist_en_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      timeout     <= timeout_nxt;
      aborted     <= aborted_nxt;
      fail_cnt    <= fail_cnt_nxt;
      run_cnt     <= run_cnt_nxt;
      last_cycles <= last_cycles_nxt;
    end
  end

endmodule

// File: tb/tb_bist_run_ctrl.sv
// Purpose: directed bench for bist_run_ctrl sessions, gaps, timeout, abort and reset.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: not applicable.
module tb_bist_run_ctrl;

  logic        clock;
  logic        n_reset;
  logic        start;
  logic        abort;
  logic [3:0]  num_runs;
  logic        b_done;
  logic        b_err;
  logic        bist_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  fail_cnt;
  logic [3:0]  run_cnt;
  logic        timeout;
  logic        aborted;
  logic [15:0] last_cycles;

  int chk_cnt;
  int pass_cnt;

  bist_run_ctrl #(
    .RUN_W(4), .CNT_W(16), .TIMEOUT(4000), .GAP(2)
  ) dut (
    .clock(clock), .n_reset(n_reset), .start(start), .abort(abort),
    .num_runs(num_runs), .b_done(b_done), .b_err(b_err), .bist_en(bist_en),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .run_cnt(run_cnt), .timeout(timeout), .aborted(aborted),
    .last_cycles(last_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse start for one cycle; returns at the first falling edge with bist_en expected high.
  task automatic start_session(input logic [3:0] n);
    num_runs = n;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at the falling edge of bist_en-high cycle 1; b_done lands in cycle k.
  task automatic run_one(input int k, input logic err);
    repeat (k - 1) @(negedge clock);
    chk_cnt++;
    if (bist_en !== 1'b1) $display("FAIL run_en_high: bist_en=%0b expected 1", bist_en);
    else pass_cnt++;
    b_done = 1'b1;
    b_err  = err;
    @(negedge clock);
    b_done = 1'b0;
    b_err  = 1'b0;
  endtask

  // Counts falling edges with bist_en low until it rises again (bounded).
  task automatic measure_gap(output int low);
    low = 0;
    while (bist_en !== 1'b1 && low < 20) begin
      low++;
      @(negedge clock);
    end
  endtask

  // Counts falling edges until done is seen (bounded).
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; start = 0; abort = 0; num_runs = 0; b_done = 0; b_err = 0;
    repeat (3) @(negedge clock);
    chk_cnt++;
    if ({bist_en, busy, done, pass, timeout, aborted, fail_cnt, run_cnt, last_cycles} !== '0)
      $display("FAIL reset_outputs: en=%0b busy=%0b done=%0b pass=%0b runs=%0d last=%0d expected all 0",
               bist_en, busy, done, pass, run_cnt, last_cycles);
    else pass_cnt++;
    n_reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_pass();
    int cyc;
    start_session(4'd1);
    chk_cnt++;
    if (bist_en !== 1'b1 || busy !== 1'b1) $display("FAIL single_launch: en=%0b busy=%0b expected 1 1", bist_en, busy);
    else pass_cnt++;
    run_one(1540, 1'b0);
    chk_cnt++;
    if (bist_en !== 1'b0) $display("FAIL single_en_drop: bist_en=%0b expected 0", bist_en);
    else pass_cnt++;
    chk_cnt++;
    if (last_cycles !== 16'd1540) $display("FAIL single_last_cycles: got %0d expected 1540", last_cycles);
    else pass_cnt++;
    wait_done(10, cyc);
    chk_cnt++;
    if (done !== 1'b1 || cyc != 2) $display("FAIL single_done_timing: done=%0b after %0d cycles expected 1 after 2", done, cyc);
    else pass_cnt++;
    chk_cnt++;
    if (pass !== 1'b1 || run_cnt !== 4'd1 || fail_cnt !== 4'd0)
      $display("FAIL single_result: pass=%0b run=%0d fail=%0d expected 1 1 0", pass, run_cnt, fail_cnt);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1)
      $display("FAIL single_after: done=%0b busy=%0b pass=%0b expected 0 0 1", done, busy, pass);
    else pass_cnt++;
  endtask

  task automatic test_multi_err();
    int low;
    int cyc;
    start_session(4'd3);
    run_one(5, 1'b0);
    measure_gap(low);
    chk_cnt++;
    if (low != 2) $display("FAIL multi_gap1: low for %0d cycles expected 2", low);
    else pass_cnt++;
    run_one(7, 1'b1);
    chk_cnt++;
    if (fail_cnt !== 4'd1 || run_cnt !== 4'd2) $display("FAIL multi_mid: fail=%0d run=%0d expected 1 2", fail_cnt, run_cnt);
    else pass_cnt++;
    measure_gap(low);
    chk_cnt++;
    if (low != 2) $display("FAIL multi_gap2: low for %0d cycles expected 2", low);
    else pass_cnt++;
    run_one(9, 1'b0);
    wait_done(10, cyc);
    chk_cnt++;
    if (done !== 1'b1) $display("FAIL multi_done: done=%0b expected 1", done);
    else pass_cnt++;
    chk_cnt++;
    if (run_cnt !== 4'd3 || fail_cnt !== 4'd1 || pass !== 1'b0 || last_cycles !== 16'd9)
      $display("FAIL multi_result: run=%0d fail=%0d pass=%0b last=%0d expected 3 1 0 9", run_cnt, fail_cnt, pass, last_cycles);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_zero_runs();
    int cyc;
    int rises;
    start_session(4'd0);
    run_one(3, 1'b0);
    wait_done(10, cyc);
    chk_cnt++;
    if (done !== 1'b1 || run_cnt !== 4'd1 || pass !== 1'b1)
      $display("FAIL zero_result: done=%0b run=%0d pass=%0b expected 1 1 1", done, run_cnt, pass);
    else pass_cnt++;
    rises = 0;
    repeat (10) begin
      @(negedge clock);
      if (bist_en === 1'b1) rises++;
    end
    chk_cnt++;
    if (rises != 0) $display("FAIL zero_single_run: bist_en high %0d cycles after done expected 0", rises);
    else pass_cnt++;
    // abort while idle must leave the result untouched
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if (aborted !== 1'b0 || pass !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_abort: aborted=%0b pass=%0b busy=%0b expected 0 1 0", aborted, pass, busy);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int hi;
    int pulses;
    start_session(4'd2);
    hi = 0;
    while (bist_en === 1'b1 && hi < 5000) begin
      hi++;
      @(negedge clock);
    end
    chk_cnt++;
    if (hi != 4000) $display("FAIL timeout_len: bist_en high %0d cycles expected 4000", hi);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b1 || timeout !== 1'b1 || fail_cnt !== 4'd1 || run_cnt !== 4'd1 || pass !== 1'b0)
      $display("FAIL timeout_result: done=%0b to=%0b fail=%0d run=%0d pass=%0b expected 1 1 1 1 0",
               done, timeout, fail_cnt, run_cnt, pass);
    else pass_cnt++;
    chk_cnt++;
    if (last_cycles !== 16'd3) $display("FAIL timeout_last_hold: last=%0d expected 3", last_cycles);
    else pass_cnt++;
    pulses = 0;
    repeat (10) begin
      @(negedge clock);
      if (done === 1'b1 || bist_en === 1'b1) pulses++;
    end
    chk_cnt++;
    if (pulses != 0) $display("FAIL timeout_no_rerun: %0d extra done/en cycles expected 0", pulses);
    else pass_cnt++;
  endtask

  task automatic test_abort_done();
    start_session(4'd2);
    repeat (3) @(negedge clock);
    b_done = 1'b1;
    abort  = 1'b1;
    @(negedge clock);
    b_done = 1'b0;
    abort  = 1'b0;
    chk_cnt++;
    if (done !== 1'b1 || bist_en !== 1'b0) $display("FAIL abort_finish: done=%0b en=%0b expected 1 0", done, bist_en);
    else pass_cnt++;
    chk_cnt++;
    if (aborted !== 1'b1 || run_cnt !== 4'd0 || pass !== 1'b0 || timeout !== 1'b0)
      $display("FAIL abort_result: aborted=%0b run=%0d pass=%0b to=%0b expected 1 0 0 0", aborted, run_cnt, pass, timeout);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if (busy !== 1'b0 || aborted !== 1'b1) $display("FAIL abort_idle: busy=%0b aborted=%0b expected 0 1", busy, aborted);
    else pass_cnt++;
  endtask

  task automatic test_start_busy_reset();
    int cyc;
    start_session(4'd1);
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1 || bist_en !== 1'b1 || aborted !== 1'b0)
      $display("FAIL busy_start: busy=%0b en=%0b aborted=%0b expected 1 1 0", busy, bist_en, aborted);
    else pass_cnt++;
    repeat (5) @(negedge clock);
    b_done = 1'b1;
    @(negedge clock);
    b_done = 1'b0;
    chk_cnt++;
    if (last_cycles !== 16'd10 || run_cnt !== 4'd1) $display("FAIL busy_len: last=%0d run=%0d expected 10 1", last_cycles, run_cnt);
    else pass_cnt++;
    wait_done(10, cyc);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || bist_en !== 1'b0 || pass !== 1'b1)
      $display("FAIL finish_start: busy=%0b en=%0b pass=%0b expected 0 0 1", busy, bist_en, pass);
    else pass_cnt++;
    @(negedge clock);
    start_session(4'd1);
    repeat (3) @(negedge clock);
    n_reset = 1'b0;
    #1;
    chk_cnt++;
    if ({bist_en, busy, done, pass, timeout, aborted, fail_cnt, run_cnt, last_cycles} !== '0)
      $display("FAIL reset_mid_run: en=%0b busy=%0b pass=%0b last=%0d expected all 0", bist_en, busy, pass, last_cycles);
    else pass_cnt++;
    @(negedge clock);
    n_reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_cnt++;
    if (bist_en !== 1'b0 || busy !== 1'b0) $display("FAIL reset_release: en=%0b busy=%0b expected 0 0", bist_en, busy);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_single_pass();
    test_multi_err();
    test_zero_runs();
    test_timeout();
    test_abort_done();
    test_start_busy_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
